proc_n: RTL
===========

Name: proc_n

Overview:
- Parametrised successor of the team's 4-register, 6-bit multi-cycle processor.
- Generalised register count and data width; 3-bit opcode with eight instructions.
- Keeps the Run/Done handshake and a single shared bus; instructions still arrive on DIN.
- Exposes the register file flattened so benches and probe cores can observe it directly.

Parameters:
- REG_NUM, 8: number of general registers; power of two, 2..16; RW = log2(REG_NUM).
- DATAWIDTH, 16: register, bus and ALU width; must be >= 3+2*RW.

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  start request, sampled only in step T0.
- DIN  input  DATAWIDTH  instruction word in T0; immediate data in T1 of mvi.
- Done  output  1  high in the final step of every instruction.
- BusWires  output  DATAWIDTH  current shared bus value.
- Zflag  output  1  zero flag; tied 0 without the optional feature.
- Cflag  output  1  borrow/carry flag; tied 0 without the optional feature.
- RegsFlat  output  REG_NUM*DATAWIDTH  register file; R0 in the LSBs.

Behaviour:
- Reset, asynchronous, in any step: step counter=T0; all Rk, A, G and IR=0; flags=0; Done=0.
- Reset mid-instruction aborts it with no register write.
- IR width is 3+2*RW, loaded from DIN[IRW-1:0].
- IR fields: op=IR[IRW-1:IRW-3], X=IR[2RW-1:RW], Y=IR[RW-1:0].
- Step counter has 2 bits (T0..T3).
- Counter clears to T0 on the edge after Done=1, or stays at T0 while Run=0.
- With Run=1 in T0 it advances one step per clock.
- Run is ignored after T0; a started instruction always completes.
- T0: IR<=DIN. Bus=0, no other writes.
- op 000 mv Rx,Ry: T1 bus=Ry, Rx<=bus, Done.
- op 001 mvi Rx,#D: T1 bus=DIN, Rx<=bus, Done. Latency 2 cycles.
- ALU ops (010 add, 011 sub, 100 and, 101 xor):
  - T1: bus=Rx, A<=bus.
  - T2: bus=Ry, G<=A op bus.
  - T3: bus=G, Rx<=bus, Done. Latency 4 cycles.
- ALU arithmetic is modulo 2^DATAWIDTH; add/sub use unsigned wrap.
- op 110 mvnz Rx,Ry: behaviour defined under Optional Feature.
- op 111: NOP; Done in T1, no writes.
- X==Y is legal: add R2,R2 doubles R2; sub R2,R2 yields 0.
- Bus priority when several sources are enabled: G > DIN > Rk (lowest index). The decoder never enables two sources at once; the priority only defines the mux.
- Done is combinational from step and op and is high for exactly one cycle per instruction.
- Back-to-back operation: with Run held high, the next T0 immediately follows the Done cycle.

Optional Feature:
- Macro: PROC_N_FLAGS_EN.
- Defined:
  - Zflag/Cflag registers load in T3 of ALU ops only.
  - Z = (result==0).
  - C = carry-out for add; borrow (Rx<Ry unsigned) for sub; 0 for and/xor.
  - mvnz: T1 Done; if Z==0 then bus=Ry and Rx<=Ry, else bus=0 and no write. Flags are unchanged.
- Undefined:
  - No flag registers; Zflag=Cflag=0.
  - mvnz acts as NOP (Done in T1, no writes).

Test Plan (REG_NUM=8, DATAWIDTH=16; IR = {op,X,Y} in DIN[8:0]):
- Reset then mvi R0,#5 (DIN=0x040, then 0x0005) -> Done in 2nd cycle; RegsFlat[15:0]=0x0005.
- Then mvi R1,#3 (0x048, 0x0003); add R0,R1 (0x081) -> Done on 4th cycle; R0=0x0008; flags Z=0 C=0.
- Then sub R1,R0 (0x0C8) -> R1=0xFFFB; with PROC_N_FLAGS_EN C=1, Z=0.
- With PROC_N_FLAGS_EN, after sub R2,R2 (0x0D2): Z=1. mvnz R3,R0 (0x198) -> R3 unchanged (0). After add R0,R1 (Z=0), mvnz R3,R0 -> R3=R0. Without the macro, R3 stays 0 in both cases.
- Run=0 held 5 cycles -> step stays T0, Done=0, no writes. Run deasserted during T2 of add -> instruction still completes in T3.
- Assert Reset in T2 of add R0,R1 -> Done=0 and all outputs reset immediately; R0 is not written. After release, the next instruction starts from T0.

Source files
------------

// File: rtl/proc_n.sv
// proc_n: parametrised multi-cycle processor with Run/Done handshake and one shared bus.
// Optional Z/C flags and conditional move enabled by defining PROC_N_FLAGS_EN.
module proc_n #(
    parameter int REG_NUM   = 8,
    parameter int DATAWIDTH = 16
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Run,
    input  logic [DATAWIDTH-1:0]           DIN,
    output logic                           Done,
    output logic [DATAWIDTH-1:0]           BusWires,
    output logic                           Zflag,
    output logic                           Cflag,
    output logic [REG_NUM*DATAWIDTH-1:0]   RegsFlat
);

    localparam int RW  = $clog2(REG_NUM);
    localparam int IRW = 3 + 2 * RW;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_XOR  = 3'b101,
        OP_MVNZ = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef struct packed {
        logic [REG_NUM-1:0] r_in;
        logic [REG_NUM-1:0] r_out;
        logic               din_out;
        logic               g_out;
        logic               ir_in;
        logic               a_in;
        logic               g_in;
        logic               done;
    } ctrl_t;

    step_e                step_q;
    step_e                step_d;
    ctrl_t                ctrl;

    logic [IRW-1:0]       ir_q;
    logic [DATAWIDTH-1:0] a_q;
    logic [DATAWIDTH-1:0] g_q;
    logic [DATAWIDTH-1:0] r_q [REG_NUM];
    logic [DATAWIDTH-1:0] alu_res;

    op_e                  op;
    logic [RW-1:0]        rx;
    logic [RW-1:0]        ry;

    logic                 is_mv;
    logic                 is_mvi;
    logic                 is_alu;
    logic                 is_mvnz;
    logic                 is_nop;

`ifdef PROC_N_FLAGS_EN
    logic                 z_q;
    logic                 c_q;
`endif

    assign op = op_e'(ir_q[IRW-1:IRW-3]);
    assign rx = ir_q[2*RW-1:RW];
    assign ry = ir_q[RW-1:0];

    assign is_mv   = (op == OP_MV);
    assign is_mvi  = (op == OP_MVI);
    assign is_alu  = (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND) || (op == OP_XOR);
    assign is_mvnz = (op == OP_MVNZ);
    assign is_nop  = (op == OP_NOP);

    // Step counter state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    // Next step: idle in T0 until Run, return to T0 after Done
    always_comb begin
        step_d = step_q;
        unique case (step_q)
            T0: step_d = Run ? T1 : T0;
            T1: step_d = ctrl.done ? T0 : T2;
            T2: step_d = ctrl.done ? T0 : T3;
            T3: step_d = T0;
            default: step_d = T0;
        endcase
    end

    // Control outputs per step and decoded opcode
    always_comb begin
        ctrl = '0;
        unique case (step_q)
            T0: begin
                ctrl.ir_in = 1'b1;
            end
            T1: begin
                unique case (1'b1)
                    is_mv: begin
                        ctrl.r_out[ry] = 1'b1;
                        ctrl.r_in[rx]  = 1'b1;
                        ctrl.done      = 1'b1;
                    end
                    is_mvi: begin
                        ctrl.din_out   = 1'b1;
                        ctrl.r_in[rx]  = 1'b1;
                        ctrl.done      = 1'b1;
                    end
                    is_alu: begin
                        ctrl.r_out[rx] = 1'b1;
                        ctrl.a_in      = 1'b1;
                    end
`ifdef PROC_N_FLAGS_EN
                    is_mvnz: begin
                        if (!z_q) begin
                            ctrl.r_out[ry] = 1'b1;
                            ctrl.r_in[rx]  = 1'b1;
                        end
                        ctrl.done = 1'b1;
                    end
                    is_nop: begin
                        ctrl.done = 1'b1;
                    end
`else
                    is_mvnz, is_nop: begin
                        ctrl.done = 1'b1;
                    end
`endif
                    default: begin
                        ctrl.done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_alu) begin
                    ctrl.r_out[ry] = 1'b1;
                    ctrl.g_in      = 1'b1;
                end
            end
            T3: begin
                if (is_alu) begin
                    ctrl.g_out    = 1'b1;
                    ctrl.r_in[rx] = 1'b1;
                    ctrl.done     = 1'b1;
                end
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign Done = ctrl.done;

    // Bus mux: G over DIN over registers, lowest register index wins
    always_comb begin
        BusWires = '0;
        if (ctrl.g_out) begin
            BusWires = g_q;
        end else if (ctrl.din_out) begin
            BusWires = DIN;
        end else begin
            for (int k = REG_NUM - 1; k >= 0; k--) begin
                if (ctrl.r_out[k]) begin
                    BusWires = r_q[k];
                end
            end
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = a_q + BusWires;
            OP_SUB:  alu_res = a_q - BusWires;
            OP_AND:  alu_res = a_q & BusWires;
            OP_XOR:  alu_res = a_q ^ BusWires;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir_q <= '0;
            a_q  <= '0;
            g_q  <= '0;
            for (int k = 0; k < REG_NUM; k++) begin
                r_q[k] <= '0;
            end
        end else begin
            if (ctrl.ir_in) begin
                ir_q <= DIN[IRW-1:0];
            end
            if (ctrl.a_in) begin
                a_q <= BusWires;
            end
            if (ctrl.g_in) begin
                g_q <= alu_res;
            end
            for (int k = 0; k < REG_NUM; k++) begin
                if (ctrl.r_in[k]) begin
                    r_q[k] <= BusWires;
                end
            end
        end
    end

`ifdef PROC_N_FLAGS_EN
    // In T3, A still holds Rx and G the wrapped result: add carries
    // iff G < A, sub borrows iff G > A.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else if (step_q == T3 && is_alu) begin
            z_q <= (g_q == '0);
            unique case (op)
                OP_ADD:  c_q <= (g_q < a_q);
                OP_SUB:  c_q <= (g_q > a_q);
                default: c_q <= 1'b0;
            endcase
        end
    end

    assign Zflag = z_q;
    assign Cflag = c_q;
`else
    assign Zflag = 1'b0;
    assign Cflag = 1'b0;
`endif

    for (genvar gk = 0; gk < REG_NUM; gk++) begin : g_flat
        assign RegsFlat[gk*DATAWIDTH +: DATAWIDTH] = r_q[gk];
    end

endmodule
